y86_fetch: RTL and testbench

Fetch stage of the sequential Y86-64 processor. It holds the PC and a byte-addressed instruction memory, splits the instruction at PC into icode/ifun/rA/rB/valC/valP, and presents it to the decode/execute/memory stage with an instr_valid flag. When the downstream stage accepts the instruction, the block computes the next PC from cnd, valC and valM, so it also owns the PC-update step.

---
 rtl/y86_fetch.sv | 275 +++++++++++++++++++++++++++
 tb/tb_y86_fetch.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_fetch.sv
// y86_fetch: fetch and PC-update stage of the sequential Y86-64 processor.
// Holds the PC and a byte-wide instruction memory. It decodes the instruction
// at PC into icode/ifun/rA/rB/valC/valP/stat and presents it with instr_valid.
// It then steps the PC when the downstream stage accepts the instruction.
module y86_fetch #(
  parameter int          IMEM_BYTES = 1024,
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter int          AW         = $clog2(IMEM_BYTES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_en,
  input  logic [AW-1:0]      load_addr,
  input  logic [7:0]         load_data,
  input  logic               start,
  input  logic               advance,
  input  logic               cnd,
  input  logic signed [63:0] valM,
  output logic               instr_valid,
  output logic [3:0]         icode,
  output logic [3:0]         ifun,
  output logic [3:0]         rA,
  output logic [3:0]         rB,
  output logic signed [63:0] valC,
  output logic signed [63:0] valP,
  output logic [63:0]        pc,
  output logic [1:0]         stat
);

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;
  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_VALID  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  // Instruction length in bytes, by icode.
  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    logic [3:0] len;
    case (ic)
      4'h0, 4'h1, 4'h9:       len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: len = 4'd2;
      4'h3, 4'h4, 4'h5:       len = 4'd10;
      4'h7, 4'h8:             len = 4'd9;
      default:                len = 4'd1;
    endcase
    return len;
  endfunction

  // Function-code legality for a (legal) icode.
  function automatic logic ifun_ok(input logic [3:0] ic, input logic [3:0] fn);
    logic ok;
    case (ic)
      4'h2, 4'h7: ok = (fn <= 4'd6);
      4'h6:       ok = (fn <= 4'd3);
      default:    ok = (fn == 4'd0);
    endcase
    return ok;
  endfunction

  // True for instructions that carry a register-specifier byte.
  function automatic logic has_regs(input logic [3:0] ic);
    logic r;
    case (ic)
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: r = 1'b1;
      default:                                  r = 1'b0;
    endcase
    return r;
  endfunction

  // Architectural state
  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [3:0]  icode_q, icode_d;
  logic [3:0]  ifun_q, ifun_d;
  logic [3:0]  ra_q, ra_d;
  logic [3:0]  rb_q, rb_d;
  logic [63:0] valc_q, valc_d;
  logic [63:0] valp_q, valp_d;
  logic [1:0]  stat_q, stat_d;
  logic        valid_q, valid_d;

  // Instruction memory (never reset; contents survive rst_n)
  logic [7:0]  mem_q [IMEM_BYTES];
  logic        load_ok;

  // Decode datapath
  logic [7:0]  fetch_byte [10];
  logic [3:0]  dec_icode, dec_ifun, dec_ra, dec_rb;
  logic [3:0]  dec_len;
  logic [64:0] dec_end;
  logic [63:0] dec_valc, dec_valp;
  logic [1:0]  dec_stat;
  logic        dec_pc_oob, dec_range_bad, dec_insn_bad;
  logic [63:0] next_pc;

  assign load_ok = (state_q == ST_IDLE) || (state_q == ST_HALTED);

  // Program-load write port, open only while the stage is parked.
  always_ff @(posedge clk) begin
    if (load_en && load_ok) begin
      mem_q[load_addr] <= load_data;
    end
  end

  // Gather the ten bytes starting at pc (index wraps; range checked separately).
  always_comb begin
    for (int k = 0; k < 10; k++) begin
      fetch_byte[k] = mem_q[pc_q[AW-1:0] + AW'(k)];
    end
  end

  // Split the fetched bytes into fields and classify the instruction status.
  always_comb begin
    dec_icode     = fetch_byte[0][7:4];
    dec_ifun      = fetch_byte[0][3:0];
    dec_len       = instr_len(dec_icode);
    dec_end       = {1'b0, pc_q} + {61'd0, dec_len} - 65'd1;
    dec_valp      = pc_q + {60'd0, dec_len};
    dec_pc_oob    = (pc_q >= 64'(IMEM_BYTES));
    dec_range_bad = (dec_end >= 65'(IMEM_BYTES));
    dec_insn_bad  = (dec_icode > 4'hB) || !ifun_ok(dec_icode, dec_ifun);
    dec_ra        = REG_NONE;
    dec_rb        = REG_NONE;
    dec_valc      = 64'd0;
    dec_stat      = STAT_AOK;
    if (dec_pc_oob) begin
      // Even the opcode byte lies outside memory: nothing is usable.
      dec_icode = 4'h0;
      dec_ifun  = 4'h0;
      dec_stat  = STAT_ADR;
    end else if (dec_insn_bad) begin
      dec_stat = STAT_INS;
    end else if (dec_range_bad) begin
      dec_stat = STAT_ADR;
    end else begin
      if (dec_icode == 4'h0) begin
        dec_stat = STAT_HLT;
      end else begin
        dec_stat = STAT_AOK;
      end
      if (has_regs(dec_icode)) begin
        dec_ra = fetch_byte[1][7:4];
        dec_rb = fetch_byte[1][3:0];
      end else begin
        dec_ra = REG_NONE;
        dec_rb = REG_NONE;
      end
      case (dec_icode)
        4'h3, 4'h4, 4'h5: dec_valc = {fetch_byte[9], fetch_byte[8], fetch_byte[7], fetch_byte[6],
                                      fetch_byte[5], fetch_byte[4], fetch_byte[3], fetch_byte[2]};
        4'h7, 4'h8:       dec_valc = {fetch_byte[8], fetch_byte[7], fetch_byte[6], fetch_byte[5],
                                      fetch_byte[4], fetch_byte[3], fetch_byte[2], fetch_byte[1]};
        default:          dec_valc = 64'd0;
      endcase
    end
  end

  // Select the PC successor for the instruction currently presented.
  always_comb begin
    case (icode_q)
      4'h8: next_pc = valc_q;
      4'h7: begin
        if (cnd) begin
          next_pc = valc_q;
        end else begin
          next_pc = valp_q;
        end
      end
      4'h9:    next_pc = valM;
      default: next_pc = valp_q;
    endcase
  end

  // FSM next-state and register updates; everything holds unless changed.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    icode_d = icode_q;
    ifun_d  = ifun_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    valc_d  = valc_q;
    valp_d  = valp_q;
    stat_d  = stat_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = RESET_PC;
        end else begin
          state_d = state_q;
        end
      end
      ST_FETCH: begin
        icode_d = dec_icode;
        ifun_d  = dec_ifun;
        ra_d    = dec_ra;
        rb_d    = dec_rb;
        valc_d  = dec_valc;
        valp_d  = dec_valp;
        stat_d  = dec_stat;
        if ((dec_stat == STAT_AOK) || (dec_stat == STAT_HLT)) begin
          state_d = ST_VALID;
          valid_d = 1'b1;
        end else begin
          state_d = ST_HALTED;
          valid_d = 1'b0;
        end
      end
      ST_VALID: begin
        if (advance) begin
          valid_d = 1'b0;
          if (stat_q == STAT_HLT) begin
            state_d = ST_HALTED;
          end else begin
            pc_d    = next_pc;
            state_d = ST_FETCH;
          end
        end else begin
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      icode_q <= 4'h0;
      ifun_q  <= 4'h0;
      ra_q    <= REG_NONE;
      rb_q    <= REG_NONE;
      valc_q  <= 64'd0;
      valp_q  <= 64'd0;
      stat_q  <= STAT_AOK;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      valc_q  <= valc_d;
      valp_q  <= valp_d;
      stat_q  <= stat_d;
      valid_q <= valid_d;
    end
  end

  assign instr_valid = valid_q;
  assign icode       = icode_q;
  assign ifun        = ifun_q;
  assign rA          = ra_q;
  assign rB          = rb_q;
  assign valC        = valc_q;
  assign valP        = valp_q;
  assign pc          = pc_q;
  assign stat        = stat_q;

endmodule

// File: tb/tb_y86_fetch.sv
// Directed testbench for y86_fetch: hand-computed expectations per scenario.
module tb_y86_fetch;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               load_en;
  logic [9:0]         load_addr;
  logic [7:0]         load_data;
  logic               start;
  logic               advance;
  logic               cnd;
  logic signed [63:0] valM;
  logic               instr_valid;
  logic [3:0]         icode, ifun, rA, rB;
  logic signed [63:0] valC, valP;
  logic [63:0]        pc;
  logic [1:0]         stat;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  y86_fetch #(.IMEM_BYTES(1024), .RESET_PC(64'd0)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .advance(advance), .cnd(cnd),
    .valM(valM), .instr_valid(instr_valid), .icode(icode), .ifun(ifun),
    .rA(rA), .rB(rB), .valC(valC), .valP(valP), .pc(pc), .stat(stat)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_byte(input logic [9:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // start, then two cycles: leaves us in the first VALID cycle
  task automatic start_and_wait();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  // one advance pulse; leaves us in the following cycle
  task automatic do_advance(input logic c, input logic [63:0] m);
    advance = 1'b1; cnd = c; valM = m;
    tick();
    advance = 1'b0; cnd = 1'b0; valM = 64'd0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", instr_valid); end
    total++; if (pc !== 64'd0) begin bad++; $display("FAIL rst_pc got=%h want=0", pc); end
    total++; if (stat !== 2'd0) begin bad++; $display("FAIL rst_stat got=%0d want=0", stat); end
    total++; if ({icode, ifun} !== 8'h00) begin bad++; $display("FAIL rst_icode_ifun got=%h want=00", {icode, ifun}); end
    total++; if ({rA, rB} !== 8'hFF) begin bad++; $display("FAIL rst_regs got=%h want=FF", {rA, rB}); end
    total++; if (valC !== 64'd0) begin bad++; $display("FAIL rst_valC got=%h want=0", valC); end
    total++; if (valP !== 64'd0) begin bad++; $display("FAIL rst_valP got=%h want=0", valP); end
    rst_n = 1'b1;
    tick();
    tick();
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b want=0", instr_valid); end
  endtask

  task automatic test_irmovq();
    logic [7:0] prog [10];
    prog[0] = 8'h30; prog[1] = 8'hF3; prog[2] = 8'h0A;
    for (int i = 3; i < 10; i++) prog[i] = 8'h00;
    for (int i = 0; i < 10; i++) load_byte(10'(i), prog[i]);
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL irm_fetch_valid got=%b want=0", instr_valid); end
    tick();
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL irm_valid got=%b want=1", instr_valid); end
    total++; if ({icode, ifun} !== 8'h30) begin bad++; $display("FAIL irm_icode_ifun got=%h want=30", {icode, ifun}); end
    total++; if ({rA, rB} !== 8'hF3) begin bad++; $display("FAIL irm_regs got=%h want=F3", {rA, rB}); end
    total++; if (valC !== 64'd10) begin bad++; $display("FAIL irm_valC got=%h want=a", valC); end
    total++; if (valP !== 64'd10) begin bad++; $display("FAIL irm_valP got=%h want=a", valP); end
    total++; if (stat !== 2'd0) begin bad++; $display("FAIL irm_stat got=%0d want=0", stat); end
    // held while no advance; start ignored in VALID
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    total++; if (instr_valid !== 1'b1 || pc !== 64'd0 || valC !== 64'd10) begin
      bad++; $display("FAIL irm_hold got=%b/%h/%h want=1/0/a", instr_valid, pc, valC); end
    do_advance(1'b0, 64'd0);
    total++; if (pc !== 64'd10) begin bad++; $display("FAIL irm_next_pc got=%h want=a", pc); end
    apply_reset();
  endtask

  task automatic test_nop_halt();
    load_byte(10'd0, 8'h10);
    load_byte(10'd1, 8'h00);
    start_and_wait();
    total++; if (icode !== 4'h1 || valP !== 64'd1 || stat !== 2'd0) begin
      bad++; $display("FAIL nop_fields got=%h/%h/%0d want=1/1/0", icode, valP, stat); end
    do_advance(1'b0, 64'd0);
    total++; if (instr_valid !== 1'b0 || pc !== 64'd1) begin
      bad++; $display("FAIL nop_adv got=%b/%h want=0/1", instr_valid, pc); end
    tick();
    total++; if (instr_valid !== 1'b1 || icode !== 4'h0 || stat !== 2'd1 || pc !== 64'd1 || valP !== 64'd2) begin
      bad++; $display("FAIL halt_fields got=%b/%h/%0d/%h/%h want=1/0/1/1/2", instr_valid, icode, stat, pc, valP); end
    do_advance(1'b0, 64'd0);
    total++; if (instr_valid !== 1'b0 || stat !== 2'd1) begin
      bad++; $display("FAIL halted got=%b/%0d want=0/1", instr_valid, stat); end
    do_advance(1'b1, 64'd7);
    tick();
    total++; if (instr_valid !== 1'b0 || pc !== 64'd1) begin
      bad++; $display("FAIL halted_adv_ignored got=%b/%h want=0/1", instr_valid, pc); end
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (pc !== 64'd0) begin bad++; $display("FAIL halted_restart_pc got=%h want=0", pc); end
    tick();
    total++; if (instr_valid !== 1'b1 || icode !== 4'h1 || stat !== 2'd0) begin
      bad++; $display("FAIL halted_restart got=%b/%h/%0d want=1/1/0", instr_valid, icode, stat); end
    apply_reset();
  endtask

  task automatic test_jxx();
    load_byte(10'd0, 8'h73);
    load_byte(10'd1, 8'h20);
    for (int i = 2; i < 9; i++) load_byte(10'(i), 8'h00);
    start_and_wait();
    total++; if ({icode, ifun} !== 8'h73 || {rA, rB} !== 8'hFF || valC !== 64'h20 || valP !== 64'd9) begin
      bad++; $display("FAIL jxx_fields got=%h/%h/%h/%h want=73/FF/20/9", {icode, ifun}, {rA, rB}, valC, valP); end
    do_advance(1'b1, 64'h55);
    total++; if (pc !== 64'h20) begin bad++; $display("FAIL jxx_taken got=%h want=20", pc); end
    apply_reset();
    start_and_wait();
    do_advance(1'b0, 64'h55);
    total++; if (pc !== 64'd9) begin bad++; $display("FAIL jxx_not_taken got=%h want=9", pc); end
    apply_reset();
  endtask

  task automatic test_call_ret();
    load_byte(10'd0, 8'h80);
    load_byte(10'd1, 8'h30);
    for (int i = 2; i < 9; i++) load_byte(10'(i), 8'h00);
    load_byte(10'h30, 8'h90);
    load_byte(10'h40, 8'h10);
    start_and_wait();
    total++; if (icode !== 4'h8 || valC !== 64'h30 || valP !== 64'd9) begin
      bad++; $display("FAIL call_fields got=%h/%h/%h want=8/30/9", icode, valC, valP); end
    do_advance(1'b0, 64'd0);
    total++; if (pc !== 64'h30) begin bad++; $display("FAIL call_pc got=%h want=30", pc); end
    tick();
    total++; if (icode !== 4'h9 || valP !== 64'h31 || {rA, rB} !== 8'hFF) begin
      bad++; $display("FAIL ret_fields got=%h/%h/%h want=9/31/FF", icode, valP, {rA, rB}); end
    do_advance(1'b0, 64'h40);
    total++; if (pc !== 64'h40) begin bad++; $display("FAIL ret_pc got=%h want=40", pc); end
    tick();
    do_advance(1'b1, 64'h999);
    total++; if (pc !== 64'h41) begin bad++; $display("FAIL nop_ignores_cnd got=%h want=41", pc); end
    apply_reset();
    // ret to an address outside memory
    load_byte(10'd0, 8'h90);
    start_and_wait();
    do_advance(1'b0, 64'd5000);
    total++; if (pc !== 64'd5000) begin bad++; $display("FAIL ret_far_pc got=%h want=1388", pc); end
    tick();
    total++; if (instr_valid !== 1'b0 || stat !== 2'd2) begin
      bad++; $display("FAIL ret_far_adr got=%b/%0d want=0/2", instr_valid, stat); end
    apply_reset();
  endtask

  task automatic test_back_to_back();
    load_byte(10'd0, 8'h60); load_byte(10'd1, 8'h12);
    load_byte(10'd2, 8'h20); load_byte(10'd3, 8'h34);
    load_byte(10'd4, 8'h00);
    start_and_wait();
    total++; if ({icode, ifun} !== 8'h60 || {rA, rB} !== 8'h12 || valP !== 64'd2 || valC !== 64'd0) begin
      bad++; $display("FAIL opq_fields got=%h/%h/%h/%h want=60/12/2/0", {icode, ifun}, {rA, rB}, valP, valC); end
    do_advance(1'b1, 64'd0);
    tick();
    total++; if (pc !== 64'd2 || {icode, ifun} !== 8'h20 || {rA, rB} !== 8'h34 || valP !== 64'd4) begin
      bad++; $display("FAIL rrmov_fields got=%h/%h/%h/%h want=2/20/34/4", pc, {icode, ifun}, {rA, rB}, valP); end
    do_advance(1'b0, 64'd0);
    tick();
    total++; if (pc !== 64'd4 || stat !== 2'd1 || instr_valid !== 1'b1) begin
      bad++; $display("FAIL b2b_halt got=%h/%0d/%b want=4/1/1", pc, stat, instr_valid); end
    apply_reset();
  endtask

  task automatic test_ins();
    logic seen;
    load_byte(10'd0, 8'h67);
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = instr_valid;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen = seen | instr_valid;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL ins_never_valid got=%b want=0", seen); end
    total++; if (stat !== 2'd3 || {icode, ifun} !== 8'h67) begin
      bad++; $display("FAIL ins_stat got=%0d/%h want=3/67", stat, {icode, ifun}); end
    load_byte(10'd0, 8'h10);
    start_and_wait();
    total++; if (instr_valid !== 1'b1 || icode !== 4'h1 || stat !== 2'd0) begin
      bad++; $display("FAIL ins_reload got=%b/%h/%0d want=1/1/0", instr_valid, icode, stat); end
    apply_reset();
    load_byte(10'd0, 8'hC0);
    start_and_wait();
    total++; if (instr_valid !== 1'b0 || stat !== 2'd3) begin
      bad++; $display("FAIL ins_icode_c got=%b/%0d want=0/3", instr_valid, stat); end
    apply_reset();
  endtask

  task automatic test_adr();
    load_byte(10'd0, 8'h70); load_byte(10'd1, 8'hFC); load_byte(10'd2, 8'h03);
    for (int i = 3; i < 9; i++) load_byte(10'(i), 8'h00);
    load_byte(10'd1020, 8'h30);
    load_byte(10'd1023, 8'h10);
    start_and_wait();
    total++; if (icode !== 4'h7 || valC !== 64'h3FC) begin
      bad++; $display("FAIL adr_jmp got=%h/%h want=7/3fc", icode, valC); end
    do_advance(1'b1, 64'd0);
    total++; if (pc !== 64'h3FC) begin bad++; $display("FAIL adr_pc got=%h want=3fc", pc); end
    tick();
    total++; if (instr_valid !== 1'b0 || stat !== 2'd2 || valC !== 64'd0) begin
      bad++; $display("FAIL adr_irmovq got=%b/%0d/%h want=0/2/0", instr_valid, stat, valC); end
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (pc !== 64'd0) begin bad++; $display("FAIL adr_restart_pc got=%h want=0", pc); end
    tick();
    total++; if (instr_valid !== 1'b1 || icode !== 4'h7 || stat !== 2'd0) begin
      bad++; $display("FAIL adr_restart got=%b/%h/%0d want=1/7/0", instr_valid, icode, stat); end
    apply_reset();
    // last byte of memory is legal; the byte after it is not
    load_byte(10'd1, 8'hFF);
    start_and_wait();
    do_advance(1'b1, 64'd0);
    tick();
    total++; if (instr_valid !== 1'b1 || stat !== 2'd0 || pc !== 64'h3FF || valP !== 64'h400) begin
      bad++; $display("FAIL adr_edge_ok got=%b/%0d/%h/%h want=1/0/3ff/400", instr_valid, stat, pc, valP); end
    do_advance(1'b0, 64'd0);
    tick();
    total++; if (instr_valid !== 1'b0 || stat !== 2'd2 || pc !== 64'h400) begin
      bad++; $display("FAIL adr_edge_out got=%b/%0d/%h want=0/2/400", instr_valid, stat, pc); end
    apply_reset();
  endtask

  task automatic test_load_start();
    load_en = 1'b1; load_addr = 10'd0; load_data = 8'h10; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    tick();
    total++; if (instr_valid !== 1'b1 || icode !== 4'h1) begin
      bad++; $display("FAIL load_start got=%b/%h want=1/1", instr_valid, icode); end
    apply_reset();
  endtask

  task automatic test_reset_mid();
    load_byte(10'd0, 8'h10);
    load_byte(10'd1, 8'h10);
    start_and_wait();
    do_advance(1'b0, 64'd0);
    // now in FETCH at pc 1
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (instr_valid !== 1'b0 || pc !== 64'd0 || stat !== 2'd0) begin
      bad++; $display("FAIL rst_in_fetch got=%b/%h/%0d want=0/0/0", instr_valid, pc, stat); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_fetch_idle got=%b want=0", instr_valid); end
    start_and_wait();
    do_advance(1'b0, 64'd0);
    tick();
    total++; if (instr_valid !== 1'b1 || pc !== 64'd1) begin
      bad++; $display("FAIL pre_rst_valid got=%b/%h want=1/1", instr_valid, pc); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (instr_valid !== 1'b0 || pc !== 64'd0 || icode !== 4'h0 || {rA, rB} !== 8'hFF) begin
      bad++; $display("FAIL rst_in_valid got=%b/%h/%h/%h want=0/0/0/FF", instr_valid, pc, icode, {rA, rB}); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    start_and_wait();
    total++; if (instr_valid !== 1'b1 || icode !== 4'h1) begin
      bad++; $display("FAIL rst_prog_kept got=%b/%h want=1/1", instr_valid, icode); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; load_en = 1'b0; load_addr = 10'd0; load_data = 8'd0;
    start = 1'b0; advance = 1'b0; cnd = 1'b0; valM = 64'd0;
    test_reset();
    test_irmovq();
    test_nop_halt();
    test_jxx();
    test_call_ret();
    test_back_to_back();
    test_ins();
    test_adr();
    test_load_start();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
